// File: rtl/ndata_packer.sv
// Re-aggregates lane-0-packed partial beats into dense NUM_ELEMENTS-wide beats.
// A partial beat is emitted only at stream end; outputs are driven from registers.
module ndata_packer #(
    parameter type data_t       = logic [7:0],
    parameter int  NUM_ELEMENTS = 4,
    parameter int  COUNT_WIDTH  = $clog2(2 * NUM_ELEMENTS)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_ELEMENTS*$bits(data_t)-1:0] in_data_i,
    input  logic [NUM_ELEMENTS-1:0]               in_keep_i,
    input  logic                                  in_last_i,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    output logic [NUM_ELEMENTS*$bits(data_t)-1:0] out_data_o,
    output logic [NUM_ELEMENTS-1:0]               out_keep_o,
    output logic                                  out_last_o,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i
);
    localparam int N     = NUM_ELEMENTS;
    localparam int DW    = $bits(data_t);
    localparam int DEPTH = 2 * N;
    localparam logic [COUNT_WIDTH-1:0] N_C = COUNT_WIDTH'(N);

    data_t                  elem_q [DEPTH];
    data_t                  elem_d [DEPTH];
    data_t                  in_lane [N];
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   last_pend_q, last_pend_d;
    logic [COUNT_WIDTH-1:0] in_cnt;
    logic [COUNT_WIDTH-1:0] base;
    logic [COUNT_WIDTH:0]   cnt_sum;
    logic                   full;
    logic                   out_fire;
    logic                   in_fire;
    logic                   shift;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            assign in_lane[gi]               = data_t'(in_data_i[gi*DW +: DW]);
            assign out_data_o[gi*DW +: DW]   = elem_q[gi];
            assign out_keep_o[gi]            = full | (cnt_q > COUNT_WIDTH'(gi));
        end
    endgenerate

    assign full        = (cnt_q >= N_C);
    assign out_valid_o = full | last_pend_q;
    assign out_last_o  = last_pend_q & (cnt_q <= N_C);
    assign out_fire    = out_valid_o & out_ready_i;
    assign in_ready_o  = rst_n & ~last_pend_q & (~full | out_fire);
    assign in_fire     = in_valid_i & in_ready_o;
    // A non-final output beat frees the low half in the same cycle new data lands.
    assign shift       = out_fire & ~out_last_o;
    assign base        = shift ? (cnt_q - N_C) : cnt_q;
    assign cnt_sum     = {1'b0, base} + {1'b0, in_cnt};

    always_comb begin
        in_cnt = '0;
        for (int j = 0; j < N; j++) begin
            in_cnt = in_cnt + COUNT_WIDTH'(in_keep_i[j]);
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            elem_d[i] = elem_q[i];
        end
        if (shift) begin
            for (int i = 0; i < N; i++) begin
                elem_d[i] = elem_q[i + N];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < N; j++) begin
                if (in_fire && (COUNT_WIDTH'(j) < in_cnt) &&
                    (COUNT_WIDTH'(i) == base + COUNT_WIDTH'(j))) begin
                    elem_d[i] = in_lane[j];
                end
            end
        end
    end

    always_comb begin
        cnt_d       = base;
        last_pend_d = last_pend_q;
        if (out_fire && out_last_o) begin
            cnt_d       = '0;
            last_pend_d = 1'b0;
        end
        if (in_fire) begin
            cnt_d = cnt_sum[COUNT_WIDTH-1:0];
            if (in_last_i) begin
                last_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            last_pend_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            last_pend_q <= last_pend_d;
            if (in_fire) begin
                assert (cnt_sum < (COUNT_WIDTH+1)'(DEPTH));
            end
        end
    end

    // Buffer contents are don't-care after reset, so they carry no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            elem_q[i] <= elem_d[i];
        end
    end

endmodule

// File: tb/tb_ndata_packer.sv
// Directed and random stimulus for ndata_packer (N=4, byte elements), checked
// against an element-queue model of stream packing.
module tb_ndata_packer;
    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_keep;
    logic            in_last;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] out_data;
    logic [N-1:0]    out_keep;
    logic            out_last;
    logic            out_valid;
    logic            out_ready;

    always #5 clk = ~clk;

    ndata_packer #(
        .data_t       (logic [7:0]),
        .NUM_ELEMENTS (N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data_i   (in_data),
        .in_keep_i   (in_keep),
        .in_last_i   (in_last),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_keep_o  (out_keep),
        .out_last_o  (out_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [7:0]  pend [$];
    logic [31:0] exp_data [$];
    logic [3:0]  exp_keep [$];
    bit          exp_last [$];
    int          rdy_mode;
    int          beats_out;
    bit          last_in_fire;
    bit          chk_valid_in_reset;
    bit          prev_hold;
    logic [31:0] prev_data;
    logic [3:0]  prev_keep;
    logic        prev_last;
    int          waited;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_assert++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic logic [3:0] therm(input int k);
        return 4'((1 << k) - 1);
    endfunction

    task automatic emit(input int cnt, input bit last);
        logic [31:0] d;
        d = '0;
        for (int j = 0; j < cnt; j++) d[j*8 +: 8] = pend.pop_front();
        exp_data.push_back(d);
        exp_keep.push_back(therm(cnt));
        exp_last.push_back(last);
    endtask

    // Stream-level packing: full beats as soon as N elements exist; at last,
    // full beats while more than N remain, then the remainder (0..N) with last.
    task automatic model_push(input int k, input logic [31:0] data, input bit last);
        for (int j = 0; j < k; j++) pend.push_back(data[j*8 +: 8]);
        if (!last) begin
            while (pend.size() >= N) emit(N, 1'b0);
        end else begin
            while (pend.size() > N) emit(N, 1'b0);
            emit(pend.size(), 1'b1);
        end
    endtask

    task automatic tick();
        logic [31:0] masked;
        bit          exp_rdy;
        @(negedge clk);
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
        #1;
        last_in_fire = 1'b0;
        if (!rst_n) begin
            check("in_ready_in_reset", 64'(in_ready), 64'(0));
            if (chk_valid_in_reset) check("out_valid_in_reset", 64'(out_valid), 64'(0));
            pend.delete();
            exp_data.delete();
            exp_keep.delete();
            exp_last.delete();
            prev_hold = 1'b0;
        end else begin
            check("out_valid", 64'(out_valid), 64'(exp_keep.size() != 0));
            exp_rdy = (exp_keep.size() == 0) ||
                      (out_ready && exp_keep.size() == 1 && !exp_last[0]);
            check("in_ready", 64'(in_ready), 64'(exp_rdy));
            if (prev_hold) begin
                check("hold_data", 64'(out_data), 64'(prev_data));
                check("hold_keep", 64'(out_keep), 64'(prev_keep));
                check("hold_last", 64'(out_last), 64'(prev_last));
            end
            if (out_valid && out_ready && exp_keep.size() != 0) begin
                for (int j = 0; j < N; j++)
                    masked[j*8 +: 8] = out_keep[j] ? out_data[j*8 +: 8] : 8'h00;
                check("beat_keep", 64'(out_keep), 64'(exp_keep[0]));
                check("beat_last", 64'(out_last), 64'(exp_last[0]));
                check("beat_data", 64'(masked), 64'(exp_data[0]));
                void'(exp_data.pop_front());
                void'(exp_keep.pop_front());
                void'(exp_last.pop_front());
                beats_out++;
            end
            if (in_valid && in_ready) begin
                model_push($countones(in_keep), in_data, in_last);
                last_in_fire = 1'b1;
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_keep = out_keep;
            prev_last = out_last;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input bit last, output int w);
        in_valid = 1'b1;
        in_keep  = therm(k);
        in_data  = $urandom();
        in_last  = last;
        w = 0;
        do begin
            tick();
            w++;
        end while (!last_in_fire && w < 200);
        check("send_accepted", 64'(last_in_fire), 64'(1));
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_keep  = '0;
        in_data  = $urandom();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_keep.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("drained", 64'(exp_keep.size()), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_keep = '0; in_last = 1'b0;
        in_data = '0; out_ready = 1'b1; rdy_mode = 0;
        prev_hold = 1'b0; chk_valid_in_reset = 1'b0; beats_out = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // k=3,3,2(last) packs into exactly two full beats
        beats_out = 0;
        send(3, 1'b0, waited);
        send(3, 1'b0, waited);
        send(2, 1'b1, waited);
        drain();
        check("t1_beat_count", 64'(beats_out), 64'(2));

        // full-rate k=4 beats never stall, then an empty last beat
        for (int i = 0; i < 16; i++) begin
            send(4, 1'b0, waited);
            check("t2_no_stall", 64'(waited), 64'(1));
        end
        send(0, 1'b1, waited);
        drain();

        // backpressure holds e0..e3 while 6 elements are buffered
        rdy_mode = 2;
        send(3, 1'b0, waited);
        send(3, 1'b0, waited);
        repeat (12) tick();
        rdy_mode = 0;
        repeat (3) tick();
        send(2, 1'b1, waited);
        drain();

        // empty last beat after a partial, and into an empty buffer
        send(2, 1'b0, waited);
        send(0, 1'b1, waited);
        drain();
        send(0, 1'b1, waited);
        drain();

        // the next stream waits until the final beat has fired
        send(3, 1'b0, waited);
        send(3, 1'b1, waited);
        send(4, 1'b0, waited);
        check("t5_next_stream_wait", 64'(waited), 64'(3));
        send(1, 1'b1, waited);
        drain();

        // reset mid-stream discards buffered elements
        send(3, 1'b0, waited);
        rst_n = 1'b0;
        chk_valid_in_reset = 1'b1;
        tick();
        chk_valid_in_reset = 1'b0;
        rst_n = 1'b1;
        send(4, 1'b1, waited);
        drain();

        // random beat sizes, stream ends and output backpressure
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            send($urandom_range(0, 4), ($urandom_range(0, 4) == 0), waited);
        end
        send($urandom_range(0, 4), 1'b1, waited);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
